// File: rtl/spi_seq_pkg.sv
// Shared types for the SPI byte sequencer: FSM state encoding and the TX FIFO entry layout.
package spi_seq_pkg;

  localparam int BYTE_W  = 8;
  localparam int ENTRY_W = BYTE_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic              last;
    logic [BYTE_W-1:0] data;
  } tx_entry_t;

endpackage

// File: rtl/spi_seq_fifo.sv
// Synchronous FIFO for the sequencer TX path; power-of-2 DEPTH, wrapping pointers plus an occupancy count.
module spi_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds the SPI byte engine from a TX FIFO, captures RX bytes, frames cs_n across multi-byte transfers.
// Optional engine watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_byte_sequencer
  import spi_seq_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_last,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              eng_start,
  output logic [BYTE_W-1:0] eng_data,
  input  logic              eng_done,
  input  logic [BYTE_W-1:0] eng_rdata,
  output logic              cs_n,
  output logic              busy,
  output logic              err_timeout
);

  seq_state_t        r_state, w_state_nxt;
  logic              r_eng_start, w_eng_start_nxt;
  logic [BYTE_W-1:0] r_eng_data, w_eng_data_nxt;
  logic              r_cs_n, w_cs_n_nxt;
  logic [BYTE_W-1:0] r_rx_data, w_rx_data_nxt;
  logic              r_rx_valid, w_rx_valid_nxt;
  logic              r_last, w_last_nxt;

  logic              w_full, w_empty, w_flush, w_issue, w_can_issue, w_timeout;
  tx_entry_t         w_wr_entry, w_head;

  assign w_wr_entry  = '{last: tx_last, data: tx_data};
  assign w_can_issue = !w_empty && !r_rx_valid;

  spi_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (w_flush),
    .push  (tx_valid),
    .wdata (w_wr_entry),
    .pop   (w_issue),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic             r_err_timeout;

  // Counts cycles since the byte was issued; eng_done on the limit cycle still completes normally.
  assign w_timeout = (r_state == ST_WAIT) && !eng_done &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_wait_cnt_nxt = r_wait_cnt;
    if (w_issue)                                         w_wait_cnt_nxt = '0;
    else if (r_state == ST_ISSUE || r_state == ST_WAIT)  w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_err_timeout <= w_timeout;
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_eng_start_nxt = 1'b0;
    w_eng_data_nxt  = r_eng_data;
    w_cs_n_nxt      = r_cs_n;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = r_rx_valid;
    w_last_nxt      = r_last;
    w_issue         = 1'b0;
    w_flush         = 1'b0;

    if (r_rx_valid && rx_ready) w_rx_valid_nxt = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_cs_n_nxt = 1'b1;
        w_issue    = w_can_issue;
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          w_rx_data_nxt  = eng_rdata;
          w_rx_valid_nxt = 1'b1;
          if (r_last) begin
            w_cs_n_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end else if (w_timeout) begin
          w_flush     = 1'b1;
          w_cs_n_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: w_issue = w_can_issue;
      default: w_state_nxt = ST_IDLE;
    endcase

    // Issue is the only place the FIFO is popped; the engine sees the byte one cycle later.
    if (w_issue) begin
      w_state_nxt     = ST_ISSUE;
      w_eng_start_nxt = 1'b1;
      w_eng_data_nxt  = w_head.data;
      w_cs_n_nxt      = 1'b0;
      w_last_nxt      = w_head.last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_eng_start <= 1'b0;
      r_eng_data  <= '0;
      r_cs_n      <= 1'b1;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_eng_start <= w_eng_start_nxt;
      r_eng_data  <= w_eng_data_nxt;
      r_cs_n      <= w_cs_n_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_last      <= w_last_nxt;
    end
  end

  assign tx_ready  = !w_full;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign eng_start = r_eng_start;
  assign eng_data  = r_eng_data;
  assign cs_n      = r_cs_n;
  assign busy      = (r_state != ST_IDLE) || !w_empty;

endmodule
